// File: rtl/sram_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module   : sram_mem_controller
//  Purpose  : Word-addressed main-memory model and controller behind the
//             cache controller. It services one read or write at a time with
//             a fixed, parameterised latency and returns read data on a held
//             output register.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk         in   1   system clock, rising edge
//    reset       in   1   synchronous, active-high
//    addr_sram   in   AW  word address, sampled on accept only
//    wdata_sram  in   DW  write data, sampled on accept only
//    rd_sram     in   1   read request
//    wr_sram     in   1   write request
//    rdata_sram  out  DW  read data register, held until the next read
//    ready_sram  out  1   idle-and-free or response cycle (combinational)
//    err_sram    out  1   one-cycle pulse when rd and wr arrive together
// ============================================================================
module sram_mem_controller #(
    parameter int AW     = 17,
    parameter int DW     = 32,
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 2
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic [AW-1:0] addr_sram,
    input  logic [DW-1:0] wdata_sram,
    input  logic          rd_sram,
    input  logic          wr_sram,
    output logic [DW-1:0] rdata_sram,
    output logic          ready_sram,
    output logic          err_sram
);

    // Counter reload values: a latency of 0 behaves like 1, so the reload
    // value saturates at 0.
    localparam logic [3:0] c_RD_CNT_INIT = (RD_LAT <= 1) ? 4'd0 : 4'(RD_LAT - 1);
    localparam logic [3:0] c_WR_CNT_INIT = (WR_LAT <= 1) ? 4'd0 : 4'(WR_LAT - 1);
    localparam int         c_DEPTH       = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q,   state_d;
    logic [3:0]    lat_cnt_q, lat_cnt_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic          is_rd_q,   is_rd_d;
    logic [DW-1:0] rdata_q,   rdata_d;
    logic          err_q,     err_d;
    logic          mem_we;

    // Storage array; deliberately never cleared.
    logic [DW-1:0] mem [0:c_DEPTH-1];

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_rd_d   = is_rd_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rd_sram || wr_sram) begin
                    addr_d    = addr_sram;
                    wdata_d   = wdata_sram;
                    // A simultaneous rd+wr keeps the read and drops the write.
                    is_rd_d   = rd_sram;
                    lat_cnt_d = rd_sram ? c_RD_CNT_INIT : c_WR_CNT_INIT;
                    err_d     = rd_sram && wr_sram;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (lat_cnt_q == 4'd0) begin
                    if (is_rd_q) begin
                        rdata_d = mem[addr_q];
                    end else begin
                        mem_we  = 1'b1;
                    end
                    state_d = S_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lat_cnt_q <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_rd_q   <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_rd_q   <= is_rd_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Reset in the commit cycle aborts the write.
    always_ff @(posedge Clk) begin
        if (mem_we && !reset) begin
            mem[addr_q] <= wdata_q;
        end
    end

    // Ready drops combinationally as soon as a request appears in IDLE, so a
    // requester never mistakes the idle ready for its own response.
    assign ready_sram = ((state_q == S_IDLE) && !rd_sram && !wr_sram) ||
                        (state_q == S_RESP);
    assign rdata_sram = rdata_q;
    assign err_sram   = err_q;

endmodule
`default_nettype wire
